// File: rtl/usb_pkg.sv
// Shared USB transmit-path types: packet select codes, handshake PID encoding
// and default scheduler timeouts.
package usb_pkg;

   typedef enum logic [2:0] {
      OUT     = 3'd0,
      IN      = 3'd1,
      DATA0   = 3'd2,
      DATA1   = 3'd3,
      ACK     = 3'd4,
      NAK     = 3'd5,
      STALL   = 3'd6,
      TX_NONE = 3'd7
   } tx_packet_t;

   typedef enum logic [1:0] {
      HS_ACK       = 2'd0,
      HS_NAK       = 2'd1,
      HS_STALL     = 2'd2,
      HS_STALL_ALT = 2'd3
   } hs_pid_t;

   localparam int unsigned DEF_START_TO   = 32'd32;
   localparam int unsigned DEF_ACK_TO     = 32'd200;
   localparam int unsigned DEF_GAP_CYCLES = 32'd16;

   // Unknown handshake codes fall back to STALL so the host never sees a bogus ACK.
   function automatic tx_packet_t hs_to_packet(input logic [1:0] pid);
      tx_packet_t pkt;
      case (hs_pid_t'(pid))
         HS_ACK:  pkt = ACK;
         HS_NAK:  pkt = NAK;
         default: pkt = STALL;
      endcase
      return pkt;
   endfunction

   function automatic tx_packet_t data_packet(input logic toggle);
      tx_packet_t pkt;
      if (toggle) begin
         pkt = DATA1;
      end else begin
         pkt = DATA0;
      end
      return pkt;
   endfunction

endpackage

// File: rtl/usb_tx_sched_if.sv
// Request/grant, host-reply and usb_tx signals around the transmit scheduler.
interface usb_tx_sched_if;
   import usb_pkg::*;

   logic       hs_req;
   logic [1:0] hs_pid;
   logic       hs_grant;
   logic       data_req;
   logic       data_grant;
   logic       toggle_clear;
   logic       host_ack;
   logic       host_nak;
   tx_packet_t tx_packet;
   logic       tx_transfer_active;
   logic       tx_error;
   logic       data_toggle;
   logic       sched_busy;
   logic       xfer_done;
   logic       xfer_nak;
   logic       xfer_fail;

   modport slave (
      input  hs_req, hs_pid, data_req, toggle_clear, host_ack, host_nak,
             tx_transfer_active, tx_error,
      output hs_grant, data_grant, tx_packet, data_toggle, sched_busy,
             xfer_done, xfer_nak, xfer_fail
   );

   modport master (
      output hs_req, hs_pid, data_req, toggle_clear, host_ack, host_nak,
             tx_transfer_active, tx_error,
      input  hs_grant, data_grant, tx_packet, data_toggle, sched_busy,
             xfer_done, xfer_nak, xfer_fail
   );

endinterface

// File: rtl/usb_sched_timer.sv
// Shared 16-bit up-counter with synchronous clear and terminal-count compare.
module usb_sched_timer (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        clr_i,
   input  logic [15:0] tc_i,
   output logic        tc_hit_o
);

   logic [15:0] count_q;
   logic [15:0] count_d;

   always_comb begin
      if (clr_i) begin
         count_d = 16'd0;
      end else begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         count_q <= 16'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_hit_o = (count_q == tc_i);

endmodule

// File: rtl/usb_tx_sched.sv
// Transmit scheduler in front of usb_tx: arbitrates handshake vs data packets,
// owns the data toggle, tracks the host reply and enforces the inter-packet gap.
module usb_tx_sched
   import usb_pkg::*;
#(
   parameter int unsigned START_TO   = DEF_START_TO,
   parameter int unsigned ACK_TO     = DEF_ACK_TO,
   parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
   input  logic            clk,
   input  logic            n_rst,
   usb_tx_sched_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      ACTIVE  = 3'd2,
      WAIT_HS = 3'd3,
      GAP     = 3'd4
   } state_t;

   localparam logic [15:0] START_TC = 16'(START_TO - 32'd1);
   localparam logic [15:0] ACK_TC   = 16'(ACK_TO - 32'd1);
   localparam logic [15:0] GAP_TC   = 16'(GAP_CYCLES - 32'd1);

   state_t     state_q, state_d;
   tx_packet_t pkt_q, pkt_d;
   tx_packet_t tx_packet_q, tx_packet_d;
   logic       is_data_q, is_data_d;
   logic       err_q, err_d;
   logic       toggle_q, toggle_d;
   logic       hs_grant_q, hs_grant_d;
   logic       data_grant_q, data_grant_d;
   logic       done_q, done_d;
   logic       nak_q, nak_d;
   logic       fail_q, fail_d;
   logic       busy_q, busy_d;
   logic       ack_flip_s;
   logic       state_change_s;
   logic       tc_hit_s;
   logic [15:0] tc_s;

   // Counter restarts on every state entry, so each timed state measures from its own start.
   assign state_change_s = (state_d != state_q);

   usb_sched_timer u_timer (
      .clk      (clk),
      .n_rst    (n_rst),
      .clr_i    (state_change_s),
      .tc_i     (tc_s),
      .tc_hit_o (tc_hit_s)
   );

   always_comb begin
      case (state_q)
         ISSUE:   tc_s = START_TC;
         WAIT_HS: tc_s = ACK_TC;
         GAP:     tc_s = GAP_TC;
         default: tc_s = 16'hFFFF;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      pkt_d        = pkt_q;
      is_data_d    = is_data_q;
      err_d        = err_q;
      tx_packet_d  = TX_NONE;
      hs_grant_d   = 1'b0;
      data_grant_d = 1'b0;
      done_d       = 1'b0;
      nak_d        = 1'b0;
      fail_d       = 1'b0;
      ack_flip_s   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.hs_req) begin
               hs_grant_d  = 1'b1;
               pkt_d       = hs_to_packet(bus.hs_pid);
               tx_packet_d = hs_to_packet(bus.hs_pid);
               is_data_d   = 1'b0;
               state_d     = ISSUE;
            end else if (bus.data_req) begin
               data_grant_d = 1'b1;
               pkt_d        = data_packet(toggle_q);
               tx_packet_d  = data_packet(toggle_q);
               is_data_d    = 1'b1;
               state_d      = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (bus.tx_transfer_active) begin
               err_d   = 1'b0;
               state_d = ACTIVE;
            end else if (tc_hit_s) begin
               fail_d  = 1'b1;
               state_d = GAP;
            end else begin
               tx_packet_d = pkt_q;
            end
         end
         ACTIVE: begin
            err_d = err_q | bus.tx_error;
            if (bus.tx_transfer_active) begin
               state_d = ACTIVE;
            end else if (err_d) begin
               fail_d  = 1'b1;
               state_d = GAP;
            end else if (!is_data_q) begin
               done_d  = 1'b1;
               state_d = GAP;
            end else begin
               state_d = WAIT_HS;
            end
         end
         WAIT_HS: begin
            // ACK outranks NAK, which outranks the reply timeout.
            if (bus.host_ack) begin
               ack_flip_s = 1'b1;
               done_d     = 1'b1;
               state_d    = GAP;
            end else if (bus.host_nak) begin
               nak_d   = 1'b1;
               state_d = GAP;
            end else if (tc_hit_s) begin
               fail_d  = 1'b1;
               state_d = GAP;
            end else begin
               state_d = WAIT_HS;
            end
         end
         GAP: begin
            if (tc_hit_s) begin
               state_d = IDLE;
            end else begin
               state_d = GAP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      toggle_d = bus.toggle_clear ? 1'b0 : (toggle_q ^ ack_flip_s);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         pkt_q        <= TX_NONE;
         tx_packet_q  <= TX_NONE;
         is_data_q    <= 1'b0;
         err_q        <= 1'b0;
         toggle_q     <= 1'b0;
         hs_grant_q   <= 1'b0;
         data_grant_q <= 1'b0;
         done_q       <= 1'b0;
         nak_q        <= 1'b0;
         fail_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pkt_q        <= pkt_d;
         tx_packet_q  <= tx_packet_d;
         is_data_q    <= is_data_d;
         err_q        <= err_d;
         toggle_q     <= toggle_d;
         hs_grant_q   <= hs_grant_d;
         data_grant_q <= data_grant_d;
         done_q       <= done_d;
         nak_q        <= nak_d;
         fail_q       <= fail_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.hs_grant    = hs_grant_q;
   assign bus.data_grant  = data_grant_q;
   assign bus.tx_packet   = tx_packet_q;
   assign bus.data_toggle = toggle_q;
   assign bus.sched_busy  = busy_q;
   assign bus.xfer_done   = done_q;
   assign bus.xfer_nak    = nak_q;
   assign bus.xfer_fail   = fail_q;

endmodule

// File: tb/tb_usb_tx_sched.sv
// Directed bench for usb_tx_sched: timestamp-based reference model checked every
// cycle, plus literal expectations for packet codes, toggle values and latencies.
module tb_usb_tx_sched;

   localparam int START_TO   = 32;
   localparam int ACK_TO     = 200;
   localparam int GAP_CYCLES = 16;

   localparam int P_IDLE = 0, P_ISSUE = 1, P_ACTIVE = 2, P_WAIT = 3, P_GAP = 4;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;

   usb_tx_sched_if bus();

   usb_tx_sched #(.START_TO(START_TO), .ACK_TO(ACK_TO), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: phase plus absolute cycle stamps of when each phase began.
   int       m_ph = P_IDLE;
   int       t_mark = 0;
   bit [2:0] m_pkt = 3'd7;
   bit       m_tog = 1'b0, m_data = 1'b0, m_err = 1'b0;
   bit       m_hs_grant = 1'b0, m_data_grant = 1'b0;
   bit       m_done = 1'b0, m_nak = 1'b0, m_fail = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   always @(posedge clk) begin
      bit new_tog;
      cyc = cyc + 1;
      m_hs_grant = 1'b0; m_data_grant = 1'b0;
      m_done = 1'b0; m_nak = 1'b0; m_fail = 1'b0;
      if (!n_rst) begin
         m_ph = P_IDLE; m_pkt = 3'd7; m_tog = 1'b0; m_data = 1'b0; m_err = 1'b0;
      end else begin
         new_tog = m_tog;
         case (m_ph)
            P_IDLE: begin
               if (bus.hs_req) begin
                  m_hs_grant = 1'b1;
                  m_pkt  = (bus.hs_pid == 2'd0) ? 3'd4 : (bus.hs_pid == 2'd1) ? 3'd5 : 3'd6;
                  m_data = 1'b0; m_ph = P_ISSUE; t_mark = cyc;
               end else if (bus.data_req) begin
                  m_data_grant = 1'b1;
                  m_pkt  = m_tog ? 3'd3 : 3'd2;
                  m_data = 1'b1; m_ph = P_ISSUE; t_mark = cyc;
               end
            end
            P_ISSUE: begin
               if (bus.tx_transfer_active) begin
                  m_ph = P_ACTIVE; m_pkt = 3'd7; m_err = 1'b0;
               end else if (cyc - t_mark == START_TO) begin
                  m_fail = 1'b1; m_pkt = 3'd7; m_ph = P_GAP; t_mark = cyc;
               end
            end
            P_ACTIVE: begin
               m_err = m_err | bus.tx_error;
               if (!bus.tx_transfer_active) begin
                  if (m_err) begin m_fail = 1'b1; m_ph = P_GAP; end
                  else if (!m_data) begin m_done = 1'b1; m_ph = P_GAP; end
                  else m_ph = P_WAIT;
                  t_mark = cyc;
               end
            end
            P_WAIT: begin
               if (bus.host_ack) begin
                  new_tog = !m_tog; m_done = 1'b1; m_ph = P_GAP; t_mark = cyc;
               end else if (bus.host_nak) begin
                  m_nak = 1'b1; m_ph = P_GAP; t_mark = cyc;
               end else if (cyc - t_mark == ACK_TO) begin
                  m_fail = 1'b1; m_ph = P_GAP; t_mark = cyc;
               end
            end
            default: begin
               if (cyc - t_mark == GAP_CYCLES) m_ph = P_IDLE;
            end
         endcase
         if (bus.toggle_clear) new_tog = 1'b0;
         m_tog = new_tog;
      end
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         check("cyc_hs_grant",   bus.hs_grant,    m_hs_grant);
         check("cyc_data_grant", bus.data_grant,  m_data_grant);
         check("cyc_tx_packet",  bus.tx_packet,   m_pkt);
         check("cyc_toggle",     bus.data_toggle, m_tog);
         check("cyc_busy",       bus.sched_busy,  (m_ph != P_IDLE));
         check("cyc_done",       bus.xfer_done,   m_done);
         check("cyc_nak",        bus.xfer_nak,    m_nak);
         check("cyc_fail",       bus.xfer_fail,   m_fail);
      end
   end

   // which: 0 any grant, 1 done, 2 nak, 3 fail
   task automatic wait_out(input int which, input string nm, output int at);
      bit seen;
      seen = 1'b0;
      at = -1;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         case (which)
            0:       seen = bus.hs_grant | bus.data_grant;
            1:       seen = bus.xfer_done;
            2:       seen = bus.xfer_nak;
            default: seen = bus.xfer_fail;
         endcase
      end
      if (seen) begin
         at = cyc;
      end else begin
         checks++;
         failures++;
         $display("FAIL %s: no event within 400 cycles, expected one", nm);
      end
   endtask

   task automatic run_tx(input int dly, input int len, input bit err, output int fall_cyc);
      repeat (dly) @(negedge clk);
      bus.tx_transfer_active = 1'b1;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         bus.tx_error = err && (i == 1);
      end
      bus.tx_error = 1'b0;
      bus.tx_transfer_active = 1'b0;
      fall_cyc = cyc;
   endtask

   task automatic reply(input bit ack, input bit nak, input bit clr);
      repeat (3) @(negedge clk);
      bus.host_ack = ack; bus.host_nak = nak; bus.toggle_clear = clr;
      @(negedge clk);
      bus.host_ack = 1'b0; bus.host_nak = 1'b0; bus.toggle_clear = 1'b0;
   endtask

   task automatic data_grant_pkt(input string nm, input logic [2:0] pkt);
      int g;
      bus.data_req = 1'b1;
      wait_out(0, nm, g);
      bus.data_req = 1'b0;
      check({nm, "_grant"}, bus.data_grant, 1'b1);
      check({nm, "_pkt"}, bus.tx_packet, pkt);
   endtask

   initial begin
      int g, d, f, x;
      bus.hs_req = 1'b0; bus.hs_pid = 2'd0; bus.data_req = 1'b0; bus.toggle_clear = 1'b0;
      bus.host_ack = 1'b0; bus.host_nak = 1'b0; bus.tx_transfer_active = 1'b0; bus.tx_error = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_pkt", bus.tx_packet, 3'd7);
      check("rst_toggle", bus.data_toggle, 1'b0);
      check("rst_busy", bus.sched_busy, 1'b0);
      n_rst = 1'b1;
      @(negedge clk);

      // ACK handshake, then gap spacing to the next grant
      bus.hs_pid = 2'd0; bus.hs_req = 1'b1;
      wait_out(0, "ack_grant", g);
      bus.hs_req = 1'b0;
      check("ack_hs_grant", bus.hs_grant, 1'b1);
      check("ack_pkt", bus.tx_packet, 3'd4);
      run_tx(2, 4, 1'b0, f);
      wait_out(1, "ack_done", d);
      bus.data_req = 1'b1;
      wait_out(0, "d1_grant", g);
      bus.data_req = 1'b0;
      check("gap_spacing", g - d, 17);
      check("d1_pkt", bus.tx_packet, 3'd2);
      run_tx(1, 6, 1'b0, f);
      reply(1'b1, 1'b0, 1'b0);
      check("d1_done", bus.xfer_done, 1'b1);
      check("d1_toggle", bus.data_toggle, 1'b1);

      data_grant_pkt("d2", 3'd3);
      run_tx(0, 3, 1'b0, f);
      reply(1'b1, 1'b0, 1'b0);
      check("d2_toggle", bus.data_toggle, 1'b0);

      data_grant_pkt("d3", 3'd2);
      run_tx(0, 3, 1'b0, f);
      reply(1'b1, 1'b0, 1'b0);
      check("d3_toggle", bus.data_toggle, 1'b1);
      repeat (20) @(negedge clk);
      bus.toggle_clear = 1'b1;
      @(negedge clk);
      bus.toggle_clear = 1'b0;
      check("clr_toggle", bus.data_toggle, 1'b0);

      // No host reply: ACK timeout
      data_grant_pkt("d4", 3'd2);
      run_tx(1, 4, 1'b0, f);
      wait_out(3, "noreply_fail", x);
      check("ack_timeout_latency", x - (f + 1), 200);
      check("noreply_toggle", bus.data_toggle, 1'b0);

      // Simultaneous requests: handshake first, data only after the gap
      bus.hs_pid = 2'd1; bus.hs_req = 1'b1; bus.data_req = 1'b1;
      wait_out(0, "sim_grant", g);
      bus.hs_req = 1'b0;
      check("sim_hs_first", bus.hs_grant, 1'b1);
      check("sim_no_data", bus.data_grant, 1'b0);
      check("sim_pkt", bus.tx_packet, 3'd5);
      run_tx(0, 3, 1'b0, f);
      wait_out(1, "sim_done", d);
      wait_out(0, "sim_data_grant", g);
      bus.data_req = 1'b0;
      check("sim_spacing", g - d, 17);
      check("sim_data_pkt", bus.tx_packet, 3'd2);
      run_tx(2, 3, 1'b0, f);
      reply(1'b0, 1'b1, 1'b0);
      check("nak_pulse", bus.xfer_nak, 1'b1);
      check("nak_toggle", bus.data_toggle, 1'b0);

      // ACK and NAK together: ACK wins
      data_grant_pkt("both", 3'd2);
      run_tx(0, 2, 1'b0, f);
      reply(1'b1, 1'b1, 1'b0);
      check("both_done", bus.xfer_done, 1'b1);
      check("both_no_nak", bus.xfer_nak, 1'b0);
      check("both_toggle", bus.data_toggle, 1'b1);

      // Reset while waiting for the host reply
      data_grant_pkt("rstx", 3'd3);
      run_tx(0, 2, 1'b0, f);
      repeat (5) @(negedge clk);
      check("rstx_busy_before", bus.sched_busy, 1'b1);
      n_rst = 1'b0;
      @(negedge clk);
      check("rstx_busy", bus.sched_busy, 1'b0);
      check("rstx_pkt", bus.tx_packet, 3'd7);
      check("rstx_toggle", bus.data_toggle, 1'b0);
      check("rstx_fail", bus.xfer_fail, 1'b0);
      n_rst = 1'b1;
      @(negedge clk);

      // toggle_clear beats a coincident ACK flip
      data_grant_pkt("clrack", 3'd2);
      run_tx(0, 2, 1'b0, f);
      reply(1'b1, 1'b0, 1'b1);
      check("clrack_done", bus.xfer_done, 1'b1);
      check("clrack_toggle", bus.data_toggle, 1'b0);

      // usb_tx never starts
      bus.hs_pid = 2'd2; bus.hs_req = 1'b1;
      wait_out(0, "st_grant", g);
      bus.hs_req = 1'b0;
      check("st_pkt", bus.tx_packet, 3'd6);
      wait_out(3, "st_fail", x);
      check("start_timeout_latency", x - g, 32);

      // usb_tx error during ACTIVE; PID 3 maps to STALL
      bus.hs_pid = 2'd3; bus.hs_req = 1'b1;
      wait_out(0, "err_grant", g);
      bus.hs_req = 1'b0;
      check("err_pkt", bus.tx_packet, 3'd6);
      run_tx(1, 5, 1'b1, f);
      @(negedge clk);
      check("err_fail", bus.xfer_fail, 1'b1);
      check("err_no_done", bus.xfer_done, 1'b0);

      repeat (20) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
